// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared LSU types and word width (`WORD_SIZE, default 32)
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package types_pkg;

    localparam int WORD_W = `WORD_SIZE;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } lsu_size_t;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_WAIT,
        WR,
        RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - lane extraction/extension for loads and lane merge for sub-word stores
module lsu_align
    import types_pkg::*;
(
    input  lsu_size_t          size_i,
    input  logic               unsigned_i,
    input  logic [1:0]         addr_lo_i,
    input  logic [WORD_W-1:0]  rdata_i,
    input  logic [WORD_W-1:0]  wdata_i,
    output logic [WORD_W-1:0]  load_data_o,
    output logic [WORD_W-1:0]  merged_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sext;

    always_comb begin
        byte_lane = rdata_i[7:0];
        case (addr_lo_i)
            2'd1:    byte_lane = rdata_i[15:8];
            2'd2:    byte_lane = rdata_i[23:16];
            2'd3:    byte_lane = rdata_i[31:24];
            default: byte_lane = rdata_i[7:0];
        endcase
        // Half accesses use addr[1] only, which also force-aligns odd addresses.
        half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        sext      = !unsigned_i;
    end

    always_comb begin
        load_data_o = rdata_i;
        merged_o    = rdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_data_o = {{24{sext & byte_lane[7]}}, byte_lane};
                case (addr_lo_i)
                    2'd1:    merged_o[15:8]  = wdata_i[7:0];
                    2'd2:    merged_o[23:16] = wdata_i[7:0];
                    2'd3:    merged_o[31:24] = wdata_i[7:0];
                    default: merged_o[7:0]   = wdata_i[7:0];
                endcase
            end
            SZ_HALF: begin
                load_data_o = {{16{sext & half_lane[15]}}, half_lane};
                if (addr_lo_i[1]) begin
                    merged_o[31:16] = wdata_i[15:0];
                end else begin
                    merged_o[15:0]  = wdata_i[15:0];
                end
            end
            default: begin
                load_data_o = rdata_i;
                merged_o    = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store controller FSM over a word memory with sync read
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses return an error instead of force-aligning.
module lsu_ctrl
    import types_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);

    lsu_state_t        state_q;
    logic              we_q;
    lsu_size_t         size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [WORD_W-1:0] rsp_rdata_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [WORD_W-1:0] mem_wdata_q;

    logic [WORD_W-1:0] load_data;
    logic [WORD_W-1:0] merged_word;
    logic              misaligned;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                        ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    lsu_align u_align (
        .size_i      (size_q),
        .unsigned_i  (uns_q),
        .addr_lo_i   (addr_q[1:0]),
        .rdata_i     (mem_rdata),
        .wdata_i     (wdata_q),
        .load_data_o (load_data),
        .merged_o    (merged_word)
    );

    // Outputs are registered alongside the state: each is set on the transition into the state that owns it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        size_q      <= lsu_size_t'(req_size);
                        uns_q       <= req_unsigned;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        if ((req_size == SZ_RSVD) || misaligned) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else if (req_we && (req_size == SZ_WORD)) begin
                            state_q     <= WR;
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= req_wdata;
                        end else begin
                            state_q  <= RD;
                            mem_en_q <= 1'b1;
                        end
                    end
                end
                RD: begin
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (we_q) begin
                        state_q     <= WR;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= merged_word;
                    end else begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= load_data;
                    end
                end
                WR: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                end
                RESP: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q[ADDR_W-1:2];
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed and randomized checks of lsu_ctrl against a word-memory reference model
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_en;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    logic        mem_init;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          rsp_cnt = 0;
    int          tests = 0;
    int          fails = 0;

    function automatic logic [31:0] init_word(int i);
        if (i == 'h40) return 32'h8899AABB;
        return (32'(i) * 32'h9E3779B1) ^ 32'hC3A55A3C;
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    always @(posedge clk) begin
        if (mem_en &&  mem_we) wr_cnt++;
        if (mem_en && !mem_we) rd_cnt++;
        if (rsp_valid)         rsp_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: outcome of one access computed from the access rules on a plain word array.
    task automatic model(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output int nrd, output int nwr,
                         output logic [31:0] data, output logic err);
        int          idx;
        int          off;
        logic [31:0] word;
        logic [31:0] mask;
        idx  = int'(addr[9:2]);
        word = ref_mem[idx];
        off  = (size == 2'd0) ? int'(addr[1:0]) : (addr[1] ? 2 : 0);
        err  = (size == 2'd3) || (TRAP && (((size == 2'd1) && addr[0]) || ((size == 2'd2) && (addr[1:0] != 0))));
        data = 0;
        if (err) begin
            lat = 1; nrd = 0; nwr = 0;
        end else if (!we) begin
            lat = 3; nrd = 1; nwr = 0;
            if (size == 2'd0) begin
                data = (word >> (8 * off)) & 32'hFF;
                if (!uns && data >= 128) data = data - 256;
            end else if (size == 2'd1) begin
                data = (word >> (8 * off)) & 32'hFFFF;
                if (!uns && data >= 32768) data = data - 65536;
            end else begin
                data = word;
            end
        end else if (size == 2'd2) begin
            lat = 2; nrd = 0; nwr = 1;
            ref_mem[idx] = wdata;
        end else begin
            lat = 4; nrd = 1; nwr = 1;
            mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
            ref_mem[idx] = (word & ~mask) | ((wdata << (8 * off)) & mask);
        end
    endtask

    // Starts at a negedge with the DUT idle; returns at the negedge of the following idle cycle.
    task automatic run_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] got_data, output logic got_err);
        int   rd0, wr0, lat, n;
        int   e_lat, e_rd, e_wr;
        logic [31:0] e_data;
        logic e_err;
        bit   seen;
        model(we, size, uns, addr, wdata, e_lat, e_rd, e_wr, e_data, e_err);
        check({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
        rd0 = rd_cnt; wr0 = wr_cnt;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        seen = 0; lat = 0; got_data = 'x; got_err = 1'bx;
        for (n = 1; n <= 8 && !seen; n++) begin
            if (rsp_valid) begin
                seen = 1; lat = n; got_data = rsp_rdata; got_err = rsp_err;
                req_valid = 1'b0;
            end else begin
                // Junk requests while busy must be ignored.
                req_valid = 1'($urandom); req_we = 1'($urandom); req_size = 2'($urandom);
                req_addr = $urandom; req_wdata = $urandom;
                @(negedge clk);
            end
        end
        req_valid = 1'b0;
        check({tag, ".lat"}, lat, e_lat);
        check({tag, ".data"}, got_data, e_data);
        check({tag, ".err"}, {31'b0, got_err}, {31'b0, e_err});
        @(negedge clk);
        check({tag, ".pulse"}, {31'b0, rsp_valid}, 32'd0);
        check({tag, ".nrd"}, rd_cnt - rd0, e_rd);
        check({tag, ".nwr"}, wr_cnt - wr0, e_wr);
        if (we) check({tag, ".mem"}, mem[addr[9:2]], ref_mem[addr[9:2]]);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          wr0, rsp0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        rst = 1'b1; mem_init = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        @(negedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        check("rst.ready", {31'b0, req_ready}, 32'd1);
        check("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst.rsp_err", {31'b0, rsp_err}, 32'd0);
        check("rst.rsp_rdata", rsp_rdata, 32'd0);
        check("rst.mem_en_we", {30'b0, mem_en, mem_we}, 32'd0);
        check("rst.mem_addr", {2'b0, mem_addr}, 32'd0);
        check("rst.mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        run_req("lb", 1'b0, 2'd0, 1'b0, 32'h101, 32'h0, d, e);
        check("lb.const", d, 32'hFFFFFFAA);
        run_req("lhu", 1'b0, 2'd1, 1'b1, 32'h102, 32'h0, d, e);
        check("lhu.const", d, 32'h00008899);
        run_req("sb", 1'b1, 2'd0, 1'b0, 32'h103, 32'h12, d, e);
        check("sb.const", mem[8'h40], 32'h1299AABB);
        run_req("sw", 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, d, e);
        check("sw.const", mem[8'h40], 32'hDEADBEEF);
        run_req("lw_mis", 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, d, e);
        check("lw_mis.const", d, TRAP ? 32'h0 : 32'hDEADBEEF);
        run_req("rsvd", 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, d, e);

        // Reset lands on the RD_WAIT cycle of a half store.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
        req_addr = 32'h200; req_wdata = 32'h5555;
        wr0 = wr_cnt; rsp0 = rsp_cnt;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid.ready", {31'b0, req_ready}, 32'd1);
        check("rstmid.mem_en", {31'b0, mem_en}, 32'd0);
        check("rstmid.mem_wdata", mem_wdata, 32'd0);
        repeat (4) @(negedge clk);
        check("rstmid.nwr", wr_cnt - wr0, 0);
        check("rstmid.nrsp", rsp_cnt - rsp0, 0);
        check("rstmid.mem", mem[8'h80], ref_mem[8'h80]);
        run_req("rsvd2", 1'b1, 2'd3, 1'b0, 32'h204, 32'h1, d, e);

        for (int k = 0; k < 60; k++) begin
            run_req($sformatf("rnd%0d", k), 1'($urandom), 2'($urandom), 1'($urandom),
                    32'($urandom_range(0, 1023)), $urandom, d, e);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter: ADDR_W, 32, byte-address width; data width is fixed at `WORD_SIZE (32).
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_valid  in  1  core presents an access.
REQ-005 req_ready  out  1  controller accepts; high only in IDLE.
REQ-006 req_we  in  1  1=store, 0=load.
REQ-007 req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 req_unsigned  in  1  loads only: zero-extend (LBU/LHU) instead of sign-extend.
REQ-009 req_addr  in  ADDR_W  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 rsp_valid  out  1  one-cycle completion pulse; no backpressure.
REQ-012 rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 rsp_err  out  1  qualified by rsp_valid; access rejected.
REQ-014 mem_en / mem_we  out  1 / 1  word-memory strobe / write.
REQ-015 mem_addr  out  ADDR_W-2  word address (req_addr[ADDR_W-1:2]).
REQ-016 mem_wdata  out  32  full-word write data.
REQ-017 mem_rdata  in  32  valid the cycle after a read strobe (synchronous read, no byte enables).

Function
REQ-018 FSM states: IDLE, RD, RD_WAIT, WR, RESP.
REQ-019 IDLE with req_valid: latch all req_* fields (handshake cycle T), then go to:
- RD for loads and byte/half stores;
- WR for word stores;
- RESP with error for reserved size.
REQ-020 RD drives mem_en=1, mem_we=0 for exactly one cycle, then goes to RD_WAIT.
REQ-021 RD_WAIT samples mem_rdata; loads then go to RESP, stores go to WR.
REQ-022 Loads: rsp_rdata = lane selected by addr[1:0] (byte) or addr[1] (half), sign- or zero-extended per req_unsigned; rsp_valid at T+3.
REQ-023 WR drives mem_en=1, mem_we=1 for one cycle.
- Word stores: mem_wdata = req_wdata; rsp_valid at T+2.
- Byte/half stores (read-modify-write): only the addressed lane is replaced in the sampled word; all other lanes are unchanged; rsp_valid at T+4.
REQ-024 RESP asserts rsp_valid for one cycle, then returns to IDLE; the next request can be accepted in that IDLE cycle.
REQ-025 req_valid outside IDLE is ignored (req_ready=0); the request is not latched.
REQ-026 Error responses (reserved size, trapped misalignment) produce no memory strobe, rsp_err=1, rsp_rdata=0, and rsp_valid at T+1.
REQ-027 mem_en is never asserted outside RD/WR; mem_we is 1 only in WR.

Reset
REQ-028 rst high at an edge sets state IDLE and clears all latched fields.
- Outputs from the next cycle: rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, req_ready=1.
REQ-029 Reset mid-operation aborts the access: no rsp_valid, and no WR strobe after the reset edge.

Configuration
REQ-030 Macro LSU_MISALIGN_TRAP_EN defined: half access with addr[0]=1, or word access with addr[1:0]!=0, gives an error response per REQ-026.
REQ-031 Macro undefined: misaligned addresses are force-aligned (half ignores addr[0]; word ignores addr[1:0]) and complete normally with rsp_err=0.

Structure
REQ-032 types_pkg gains lsu_size_t (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD) and lsu_state_t (the REQ-018 states).
REQ-033 Sub-module lsu_align (combinational) holds lane extraction/extension and lane merging; lsu_ctrl holds the FSM and registers.

Verification
REQ-034 Memory word 0x100 = 0x8899AABB; LB addr 0x101 -> rsp_rdata=0xFFFFFFAA at T+3, rsp_err=0.
REQ-035 Same word; LHU addr 0x102 -> rsp_rdata=0x00008899.
REQ-036 SB addr 0x103, wdata 0x12 -> exactly one RD then one WR strobe; word becomes 0x1299AABB; rsp_valid at T+4.
REQ-037 SW addr 0x100, wdata 0xDEADBEEF -> single WR strobe, no RD; rsp_valid at T+2.
REQ-038 LW addr 0x102:
- with LSU_MISALIGN_TRAP_EN -> rsp_err=1, rsp_rdata=0, no mem_en, rsp_valid at T+1;
- without it -> reads word 0x100, rsp_err=0.
REQ-039 rst asserted during RD_WAIT of SH -> no WR strobe, no rsp_valid, memory unchanged, req_ready=1 next cycle; req_size=11 -> rsp_err=1 at T+1.
